alu_iterative: RTL and testbench

- Execution-side consumer of the 4-bit ALUControl code produced by the ALU control decoder.
- Single-issue ALU with Start/Busy/Done handshake for the multicycle datapath.
- ADD/SUB/XOR/AND/OR finish in one cycle; SRL runs a serial shifter at one bit per cycle.
- Unsupported codes, including the decoder's 4'b1111 "invalid" code, are flagged through Error rather than silently producing data.

---
 rtl/alu_iterative.sv | 123 ++++++++++++
 tb/tb_alu_iterative.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: single-issue ALU with a Start/Busy/Done handshake.
// ADD/SUB/XOR/AND/OR complete in one cycle. SRL uses a serial shifter
// that shifts one bit per cycle. Unsupported codes complete with Error=1.
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] op_res;
  logic             op_err;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];

  // Single-cycle result for the code currently presented. SRL yields A,
  // which is the correct result only for a zero shift amount.
  always_comb begin
    op_res = '0;
    op_err = 1'b0;
    case (ALUControl)
      OP_ADD:  op_res = A + B;
      OP_SUB:  op_res = A - B;
      OP_XOR:  op_res = A ^ B;
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_SRL:  op_res = A;
      default: op_err = 1'b1;
    endcase
  end

  // Next-state logic. Visible outputs are written only on the transition
  // into DONE, so intermediate shift values never reach Result.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (ALUControl == OP_SRL && shamt != '0) begin
            shreg_d = A;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            error_d  = op_err;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d = shreg_q >> 1;
          zero_d   = ((shreg_q >> 1) == '0);
          error_d  = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset overrides Start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign Error  = error_q;
  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == DONE);

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed scenarios followed by
// randomized operations, compared against a behavioural model.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  ALUControl;
  logic [31:0] A, B;
  logic [31:0] Result;
  logic        Zero, Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  // Model of the last committed outputs.
  logic [31:0] m_res;
  logic        m_zero, m_err;

  alu_iterative #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
    .A(A), .B(B), .Result(Result), .Zero(Zero), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation code.
  task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    e   = 1'b0;
    lat = 1;
    r   = 32'h0;
    case (code)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0100: r = a ^ b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0111: begin r = a >> (b % 32); lat = (b % 32) + 1; end
      default: e = 1'b1;
    endcase
  endtask

  // Issue one op and wait for Done. With noise set, Start stays high and
  // operands/code are scrambled while the op is in flight.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    logic [31:0] er;
    logic        ee;
    int          lat, cyc;
    bit          seen;
    model(code, a, b, er, ee, lat);
    @(negedge clk);
    Start = 1'b1; ALUControl = code; A = a; B = b;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        ALUControl = 4'b0010; A = $urandom; B = $urandom;
      end else begin
        Start = 1'b0;
      end
      if (cyc == 1) check({tag, " busy"}, 32'(Busy), 32'd1);
      if (Done) seen = 1'b1;
      else      check({tag, " hold"}, Result, m_res);
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, Result, er);
    check({tag, " zero"}, 32'(Zero), 32'(er == 32'h0));
    check({tag, " error"}, 32'(Error), 32'(ee));
    m_res = er; m_zero = (er == 32'h0); m_err = ee;
    @(negedge clk);
    Start = 1'b0;
    check({tag, " idle busy"}, 32'(Busy), 32'd0);
    check({tag, " idle done"}, 32'(Done), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " result"}, Result, 32'h0);
    check({tag, " zero"}, 32'(Zero), 32'd0);
    check({tag, " busy"}, 32'(Busy), 32'd0);
    check({tag, " done"}, 32'(Done), 32'd0);
    check({tag, " error"}, 32'(Error), 32'd0);
  endtask

  initial begin
    logic [3:0] codes [8];
    int         dones;
    codes = '{4'b0010, 4'b0110, 4'b0100, 4'b0000, 4'b0001, 4'b0111, 4'b1111, 4'b0011};
    reset = 1'b1; Start = 1'b0; ALUControl = 4'h0; A = '0; B = '0;
    m_res = '0; m_zero = 1'b0; m_err = 1'b0;

    // Reset held for two cycles, with Start high to show reset wins.
    @(negedge clk); Start = 1'b1; ALUControl = 4'b0010; A = 1; B = 1;
    @(negedge clk); Start = 1'b0;
    check_reset_state("reset");
    reset = 1'b0;

    run_op("add", 4'b0010, 32'd7, 32'd5, 1'b0);
    run_op("sub wrap", 4'b0110, 32'd3, 32'd5, 1'b0);
    run_op("sub zero", 4'b0110, 32'd9, 32'd9, 1'b0);
    run_op("srl 31", 4'b0111, 32'h8000_0000, 32'd31, 1'b0);
    run_op("srl 0", 4'b0111, 32'h8000_0000, 32'd0, 1'b0);
    run_op("srl 4", 4'b0111, 32'h0000_00F0, 32'h24, 1'b0);
    run_op("invalid", 4'b1111, 32'd1, 32'd1, 1'b0);
    run_op("xor", 4'b0100, 32'hFF, 32'h0F, 1'b0);
    run_op("busy start", 4'b0111, 32'hDEAD_BEEF, 32'd8, 1'b1);

    // Reset during a long shift: no Done, outputs cleared.
    @(negedge clk);
    Start = 1'b1; ALUControl = 4'b0111; A = 32'hFFFF_FFFF; B = 32'd20;
    @(negedge clk); Start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_res = '0; m_zero = 1'b0; m_err = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done) dones++;
      @(negedge clk);
    end
    check("abort no done", 32'(dones), 32'd0);
    check_reset_state("abort");
    run_op("add after abort", 4'b0010, 32'd1, 32'd1, 1'b0);

    // Randomized ops across all codes.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", codes[$urandom_range(0, 7)], $urandom, $urandom, 1'(($urandom_range(0, 3)) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
